controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/controller.sv
// Multicycle instruction controller: sequences fetch, latch, decode, execute
// and write-back for a small 16-bit ALU datapath. Control outputs are decoded
// from the current state and the instruction register contents.
module controller #(
    parameter int unsigned MEMORY_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    output logic [1:0]  alu_a_select,
    output logic        alu_b_select,
    output logic [1:0]  alu_operation,
    output logic        program_counter_write_enable,
    output logic        status_write_enable,
    output logic        instruction_write_enable,
    output logic        register_write_enable,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        LATCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    // Last wait-counter value of a fetch; memory latency is 1..4 cycles.
    localparam logic [1:0] LAST_WAIT = 2'(MEMORY_LATENCY - 1);

    state_t      current_state;
    logic [1:0]  wait_count;

    logic [3:0]  opcode;
    logic [3:0]  ext;
    logic        supported;
    logic        immediate_form;
    logic        writes_back;
    logic [1:0]  family_op;

    // Register number and immediate bits are consumed by the datapath, not here.
    logic        unused_fields;
    assign unused_fields = ^{instruction[11:8], instruction[3:0]};

    assign opcode = instruction[15:12];
    assign ext    = instruction[7:4];

    // Classify the instruction into ADD/SUB/CMP families, register or immediate form.
    always_comb begin
        supported      = 1'b0;
        immediate_form = 1'b0;
        family_op      = 2'b00;
        if (opcode == 4'b0000) begin
            case (ext)
                4'b0101: begin supported = 1'b1; family_op = 2'b00; end
                4'b1001: begin supported = 1'b1; family_op = 2'b01; end
                4'b1011: begin supported = 1'b1; family_op = 2'b10; end
                default: ;
            endcase
        end else begin
            case (opcode)
                4'b0101: begin supported = 1'b1; immediate_form = 1'b1; family_op = 2'b00; end
                4'b1001: begin supported = 1'b1; immediate_form = 1'b1; family_op = 2'b01; end
                4'b1011: begin supported = 1'b1; immediate_form = 1'b1; family_op = 2'b10; end
                default: ;
            endcase
        end
    end

    // Compares only update status; add/subtract results go to the register file.
    assign writes_back = supported && (family_op != 2'b10);

    // State sequencing; the wait counter is zero whenever FETCH is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            current_state <= FETCH;
            wait_count    <= 2'd0;
        end else begin
            case (current_state)
                FETCH: begin
                    if (wait_count == LAST_WAIT) begin
                        current_state <= LATCH;
                        wait_count    <= 2'd0;
                    end else begin
                        wait_count <= wait_count + 2'd1;
                    end
                end
                LATCH: begin
                    current_state <= DECODE;
                    wait_count    <= 2'd0;
                end
                DECODE: begin
                    current_state <= supported ? EXECUTE : FETCH;
                    wait_count    <= 2'd0;
                end
                EXECUTE: begin
                    current_state <= writes_back ? WRITEBACK : FETCH;
                    wait_count    <= 2'd0;
                end
                default: begin
                    current_state <= FETCH;
                    wait_count    <= 2'd0;
                end
            endcase
        end
    end

    // Control outputs from state plus decode; reset reaches them only through the state register.
    always_comb begin
        alu_a_select                 = 2'b00;
        alu_b_select                 = 1'b0;
        alu_operation                = 2'b00;
        program_counter_write_enable = 1'b0;
        status_write_enable          = 1'b0;
        instruction_write_enable     = 1'b0;
        register_write_enable        = 1'b0;
        case (current_state)
            LATCH: begin
                instruction_write_enable     = 1'b1;
                program_counter_write_enable = 1'b1;
                alu_a_select                 = 2'b00;
                alu_b_select                 = 1'b1;
                alu_operation                = 2'b00;
            end
            EXECUTE: begin
                if (supported) begin
                    alu_a_select        = immediate_form ? 2'b10 : 2'b01;
                    alu_operation       = family_op;
                    status_write_enable = 1'b1;
                end
            end
            WRITEBACK: begin
                register_write_enable = 1'b1;
                if (supported) begin
                    alu_a_select  = immediate_form ? 2'b10 : 2'b01;
                    alu_operation = family_op;
                end
            end
            default: ;
        endcase
    end

    assign state = current_state;

endmodule
